md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/mips_md_pkg.sv | 30 +++
 rtl/md_arith.sv | 49 ++++
 rtl/md_ctrl.sv | 113 +++++++++++
 tb/tb_md_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default busy latencies, the controller state enum, and op-class helpers
// (also used by the decoder).
package mips_md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // MULT, MULTU, DIV and DIVU all have op[2] clear.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide datapath.
// Ports:
//   op          in   3   md op code (mips_md_pkg encodings)
//   a, b        in   32  rs / rt operands
//   result      out  64  {hi, lo}: product, or {remainder, quotient}
//   div_by_zero out  1   divide op with b == 0 (result must not be committed)
module md_arith
  import mips_md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        sdiv_ovf;
  logic [31:0] b_udiv;
  logic [31:0] b_sdiv;
  logic [31:0] sq, sr, uq, ur;
  logic [63:0] sprod, uprod;

  always_comb begin
    div_by_zero = is_div(op) && (b == 32'd0);
    // -2^31 / -1 overflows a 32-bit signed divide; dividing by +1 instead
    // yields the required quotient 0x80000000 with remainder 0. A zero
    // divisor is also replaced so the divider never sees 0.
    sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    b_udiv   = (b == 32'd0) ? 32'd1 : b;
    b_sdiv   = ((b == 32'd0) || sdiv_ovf) ? 32'd1 : b;

    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    sq    = $signed(a) / $signed(b_sdiv);
    sr    = $signed(a) % $signed(b_sdiv);
    uq    = a / b_udiv;
    ur    = a % b_udiv;

    result = 64'd0;
    case (op)
      MD_MULT:  result = sprod;
      MD_MULTU: result = uprod;
      MD_DIV:   result = {sr, sq};
      MD_DIVU:  result = {ur, uq};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide controller. A MULT/DIV start captures the result
// into a pending register and runs a down-counter for the configured
// latency; HI/LO are written when the counter reaches zero. MTHI/MTLO write
// directly. Requests a pipeline stall while a D-stage HI/LO user would race
// an in-flight or just-starting operation.
// Ports:
//   clk, reset   in   1   clock, synchronous active-high reset
//   md_start     in   1   E-stage mult/div-class instruction valid
//   md_op        in   3   op code
//   src_a/src_b  in   32  forwarded rs / rt operands
//   d_is_md      in   1   D-stage instruction uses HI/LO
//   busy         out  1   MULT/DIV in progress
//   stall        out  1   freeze F/D, bubble E
//   hi, lo       out  32  architectural HI / LO
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | accepting starts; MTHI/MTLO write immediately
// ST_RUN  | counting down; result committed when cnt == 0
module md_ctrl
  import mips_md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_state_e   state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] pending;
  logic        pend_wr;
  logic [63:0] arith_res;
  logic        arith_dbz;
  logic        start_md;

  md_arith u_arith (
    .op          (md_op),
    .a           (src_a),
    .b           (src_b),
    .result      (arith_res),
    .div_by_zero (arith_dbz)
  );

  assign start_md = md_start && is_muldiv(md_op);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_md) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == 4'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == ST_RUN);
    stall = d_is_md && (busy || start_md);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      pending <= 64'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_md) begin
            pending <= arith_res;
            // A zero-divisor divide still takes the full latency but
            // leaves HI/LO untouched.
            pend_wr <= ~arith_dbz;
            cnt     <= is_div(md_op) ? DIV_LOAD : MULT_LOAD;
          end else if (md_start && (md_op == MD_MTHI)) begin
            hi <= src_a;
          end else if (md_start && (md_op == MD_MTLO)) begin
            lo <= src_a;
          end
        end
        ST_RUN: begin
          if (cnt == 4'd0) begin
            if (pend_wr) {hi, lo} <= pending;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;
  import mips_md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        d_is_md = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic [63:0] cur_hilo = 64'd0;
  int nbusy;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return 64'(ua * ub);
      MD_DIV: begin
        if (b == 32'd0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return cur;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return cur;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    #1;
  endtask

  // Ends the start cycle, then counts busy cycles; returns in the first idle cycle.
  task automatic wait_done(output int n);
    n = 0;
    tick();
    md_start = 1'b0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cur_hilo = 64'd0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_mult();
    drive(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    wait_done(nbusy);
    checks++; if (nbusy !== 5) begin errors++; $display("FAIL mult_busy_len: got %0d want 5", nbusy); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL mult_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_multu();
    drive(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    wait_done(nbusy);
    checks++; if (nbusy !== 5) begin errors++; $display("FAIL multu_busy_len: got %0d want 5", nbusy); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL multu_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_hazard();
    int scnt;
    int sbad;
    d_is_md = 1'b1;
    drive(MD_MULT, 32'd7, 32'd6);
    exp_q.push_back({32'd0, 32'd42});
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start_cycle: got %b want 1", stall); end
    scnt = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      md_start = 1'b0;
      #1;
      if (stall === 1'b1) scnt++;
    end
    checks++; if (scnt !== 5) begin errors++; $display("FAIL stall_busy_cycles: got %0d want 5", scnt); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", stall); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL hazard_mult_result: got %h want %h", {hi, lo}, exp_v); end

    d_is_md = 1'b0;
    drive(MD_MULTU, 32'd3, 32'd4);
    exp_q.push_back({32'd0, 32'd12});
    sbad = (stall !== 1'b0) ? 1 : 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      md_start = 1'b0;
      #1;
      if (stall !== 1'b0) sbad++;
    end
    checks++; if (sbad !== 0) begin errors++; $display("FAIL stall_no_d_md: got %0d stall cycles want 0", sbad); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL hazard_multu_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_div_ignore();
    int n;
    drive(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    n = 0;
    tick();
    md_start = 1'b0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == 2) drive(MD_MULT, 32'd5, 32'd5);
      else md_start = 1'b0;
      tick();
    end
    md_start = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_len: got %0d want 10", n); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL div_result: got %h want %h", {hi, lo}, exp_v); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_ignored_start_busy: got %b want 0", busy); end
  endtask

  task automatic test_mtx_divzero();
    drive(MD_MTHI, 32'h11, 32'd0);
    tick();
    md_start = 1'b0;
    cur_hilo[63:32] = 32'h11;
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mthi_hi: got %h want 11", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    drive(MD_MTLO, 32'h22, 32'd0);
    tick();
    md_start = 1'b0;
    cur_hilo[31:0] = 32'h22;
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL mtlo_lo: got %h want 22", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    drive(MD_DIVU, 32'd5, 32'd0);
    exp_q.push_back({32'h11, 32'h22});
    wait_done(nbusy);
    checks++; if (nbusy !== 10) begin errors++; $display("FAIL divzero_busy_len: got %0d want 10", nbusy); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL divzero_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_div_overflow();
    drive(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    exp_q.push_back({32'h0000_0000, 32'h8000_0000});
    wait_done(nbusy);
    checks++; if (nbusy !== 10) begin errors++; $display("FAIL div_ovf_busy_len: got %0d want 10", nbusy); end
    exp_v = exp_q.pop_front();
    cur_hilo = exp_v;
    checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL div_ovf_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_noop();
    drive(3'b110, 32'h1234, 32'h5678);
    tick();
    drive(3'b111, 32'h9abc, 32'hdef0);
    tick();
    md_start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy: got %b want 0", busy); end
    checks++; if ({hi, lo} !== cur_hilo) begin errors++; $display("FAIL noop_hilo: got %h want %h", {hi, lo}, cur_hilo); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    drive(MD_DIV, 32'd100, 32'd7);
    tick();
    md_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cur_hilo = 64'd0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_run_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_run_lo: got %h want 0", lo); end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy !== 1'b0 || {hi, lo} !== 64'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_run_late_write: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    int          want_n;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i == 3) b = 32'd0;
      else if (is_div(op) && (i % 2 == 1)) b = 32'($urandom_range(1, 9));
      want_n = is_div(op) ? 10 : 5;
      drive(op, a, b);
      exp_q.push_back(model(op, a, b, cur_hilo));
      wait_done(nbusy);
      checks++; if (nbusy !== want_n) begin errors++; $display("FAIL b2b_busy_len[%0d]: got %0d want %0d", i, nbusy, want_n); end
      exp_v = exp_q.pop_front();
      cur_hilo = exp_v;
      checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {hi, lo}, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_hazard();
    test_div_ignore();
    test_mtx_divzero();
    test_div_overflow();
    test_noop();
    test_reset_mid_run();
    test_back_to_back();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
